frame_trace_tx: RTL and testbench

- Consumer end of the physics core's per-frame state outputs (pos_o/rem_o/spd_o/exit), plus the btn vector fed to the core.
- Snapshots one frame of player state on a strobe and serialises it as a fixed 25-byte packet over a valid/ready byte stream, e.g. to a UART or a testbench logger.
- Lets the hardware trace be diffed against the reference Celeste physics.

---
 rtl/frame_trace_tx.sv | 138 +++++++++++++
 tb/tb_frame_trace_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_trace_tx.sv
`default_nettype none
// ============================================================================
// Module      : frame_trace_tx
// Description : Captures one frame of player state on a strobe and streams it
//               as a fixed 25-byte packet over a valid/ready byte interface:
//                 0      sync byte
//                 1-2    frame counter (value before this frame's increment)
//                 3      {exit, 1'b0, btn[5:0]}
//                 4-7    pos.x, pos.y        (16-bit each)
//                 8-15   rem.x, rem.y        (32-bit Q16.16 each)
//                 16-23  spd.x, spd.y        (32-bit Q16.16 each)
//                 24     XOR of bytes 1..23
//               Multi-byte fields are big-endian.
// Ports       : clk, rst (sync, active-low)
//               frame_valid, pos{x[31:16],y[15:0]}, rem{x[63:32],y[31:0]},
//               spd{x[63:32],y[31:0]}, exit, btn   - frame snapshot inputs
//               tx_data, tx_valid, tx_ready         - byte stream
//               busy                                - packet in flight
//               overruns                            - saturating drop count
// Revision    : 1.0 - initial release
// ============================================================================
module frame_trace_tx #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned DECIMATE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid,
    input  logic [31:0] pos,
    input  logic [63:0] rem,
    input  logic [63:0] spd,
    input  logic        exit,
    input  logic [5:0]  btn,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  overruns
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'd24;
    localparam logic [7:0] DEC_LAST = 8'(DECIMATE - 1);

    state_t       state;
    state_t       state_next;

    // Whole packet is held in a shift register; the head byte is always on
    // tx_data, so the byte stays stable until its handshake shifts it out.
    logic [199:0] r_shadow;
    logic [4:0]   r_idx;
    logic [15:0]  r_frame_cnt;
    logic [7:0]   r_dec_cnt;
    logic [7:0]   r_overruns;

    logic [183:0] w_body;
    logic [7:0]   w_chk;
    logic         w_hs;
    logic         w_last;
    logic         w_eligible;
    logic         w_accept;
    logic         w_drop;

    // Bytes 1..23 in transmit order, MSB first.
    assign w_body = {r_frame_cnt, exit, 1'b0, btn, pos, rem, spd};

    // Checksum is precomputed at capture so the shadow holds the full packet.
    always_comb begin
        w_chk = '0;
        for (int i = 0; i < 23; i++) begin
            w_chk = w_chk ^ w_body[i*8 +: 8];
        end
    end

    assign tx_valid   = (state == ST_SEND);
    assign busy       = tx_valid;
    assign tx_data    = r_shadow[199:192];
    assign overruns   = r_overruns;

    assign w_hs       = tx_valid && tx_ready;
    assign w_last     = w_hs && (r_idx == LAST_IDX);
    assign w_eligible = frame_valid && (r_dec_cnt == 8'd0);
    // The final handshake frees the shadow in the same cycle, allowing a
    // back-to-back capture with no idle bubble.
    assign w_accept   = w_eligible && ((state == ST_IDLE) || w_last);
    assign w_drop     = w_eligible && (state == ST_SEND) && !w_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (w_accept)            state_next = ST_SEND;
            ST_SEND: if (w_last && !w_accept) state_next = ST_IDLE;
            default:                          state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shadow    <= '0;
            r_idx       <= '0;
            r_frame_cnt <= '0;
            r_dec_cnt   <= '0;
            r_overruns  <= '0;
        end else begin
            if (w_accept) begin
                r_shadow <= {SYNC_BYTE, w_body, w_chk};
                r_idx    <= '0;
            end else if (w_hs) begin
                // Zero fill leaves tx_data at 0 once the packet has drained.
                r_shadow <= {r_shadow[191:0], 8'h00};
                r_idx    <= r_idx + 5'd1;
            end

            if (frame_valid) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_dec_cnt   <= (r_dec_cnt == DEC_LAST) ? 8'd0 : r_dec_cnt + 8'd1;
            end

            if (w_drop && (r_overruns != 8'hFF)) begin
                r_overruns <= r_overruns + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_trace_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_trace_tx
// Description : Scoreboard bench for frame_trace_tx. Two instances share the
//               stimulus (DECIMATE=1 and DECIMATE=3). A reference model
//               decides which frames become packets, builds their byte lists
//               into per-instance queues, and tracks bytes outstanding and
//               overruns; a monitor compares every presented byte.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_trace_tx;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_valid = 1'b0;
    logic [31:0] pos = '0;
    logic [63:0] rem = '0;
    logic [63:0] spd = '0;
    logic        exit_flag = 1'b0;
    logic [5:0]  btn = '0;
    logic        tx_ready = 1'b1;

    logic [1:0][7:0] tx_data;
    logic [1:0]      tx_valid;
    logic [1:0]      busy;
    logic [1:0][7:0] overruns;

    always #5 clk = ~clk;

    frame_trace_tx #(.SYNC_BYTE(SYNC), .DECIMATE(1)) u_dut0 (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .pos(pos), .rem(rem),
        .spd(spd), .exit(exit_flag), .btn(btn), .tx_data(tx_data[0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready), .busy(busy[0]),
        .overruns(overruns[0])
    );

    frame_trace_tx #(.SYNC_BYTE(SYNC), .DECIMATE(3)) u_dut1 (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .pos(pos), .rem(rem),
        .spd(spd), .exit(exit_flag), .btn(btn), .tx_data(tx_data[1]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready), .busy(busy[1]),
        .overruns(overruns[1])
    );

    // ---------------- reference model state ----------------
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         nframes;      // frames since reset, not truncated
    int         remaining[2]; // bytes of the current packet not yet accepted
    int         ovr_m[2];
    int         n_total = 0;
    int         n_pass  = 0;

    function automatic int dec_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Build the packet from the spec byte list and queue it for instance d.
    task automatic push_pkt(input int d, input logic [15:0] fc);
        logic [7:0] b [25];
        logic [7:0] x;
        b[0] = SYNC;
        b[1] = fc[15:8];
        b[2] = fc[7:0];
        b[3] = {exit_flag, 1'b0, btn};
        for (int k = 0; k < 2; k++) begin
            b[4+k] = 8'(pos[31:16] >> (8*(1-k)));
            b[6+k] = 8'(pos[15:0]  >> (8*(1-k)));
        end
        for (int k = 0; k < 4; k++) begin
            b[8+k]  = 8'(rem[63:32] >> (8*(3-k)));
            b[12+k] = 8'(rem[31:0]  >> (8*(3-k)));
            b[16+k] = 8'(spd[63:32] >> (8*(3-k)));
            b[20+k] = 8'(spd[31:0]  >> (8*(3-k)));
        end
        x = 8'h00;
        for (int k = 1; k <= 23; k++) x = x ^ b[k];
        b[24] = x;
        for (int k = 0; k < 25; k++) begin
            if (d == 0) q0.push_back(b[k]);
            else        q1.push_back(b[k]);
        end
    endtask

    // One clock cycle of stimulus; inputs are applied just after a posedge.
    task automatic cycle(input bit fv, input bit rdy, input bit rn);
        bit hs[2];
        bit acc[2];
        rst         = rn;
        frame_valid = fv;
        tx_ready    = rdy;
        for (int d = 0; d < 2; d++) begin
            hs[d]  = (remaining[d] > 0) && rdy;
            acc[d] = 1'b0;
        end
        if (rn && fv) begin
            for (int d = 0; d < 2; d++) begin
                if ((nframes % dec_of(d)) == 0) begin
                    if (remaining[d] == 0 || (remaining[d] == 1 && hs[d])) begin
                        acc[d] = 1'b1;
                        push_pkt(d, 16'(nframes));
                    end else if (ovr_m[d] < 255) begin
                        ovr_m[d]++;
                    end
                end
            end
            nframes++;
        end
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        if (!rn) begin
            q0.delete();
            q1.delete();
            nframes = 0;
            for (int d = 0; d < 2; d++) begin
                remaining[d] = 0;
                ovr_m[d]     = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (hs[d])  remaining[d]--;
                if (acc[d]) remaining[d] = 25;
            end
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("tx_valid%0d", d), int'(tx_valid[d]), int'(remaining[d] > 0));
            check($sformatf("busy%0d", d), int'(busy[d]), int'(remaining[d] > 0));
            check($sformatf("overruns%0d", d), int'(overruns[d]), ovr_m[d]);
        end
    endtask

    task automatic rand_fields();
        pos       = $urandom;
        rem       = {$urandom, $urandom};
        spd       = {$urandom, $urandom};
        exit_flag = 1'($urandom_range(0, 1));
        btn       = 6'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (remaining[0] == 0 && remaining[1] == 0) break;
            cycle(1'b0, 1'b1, 1'b1);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic mon(input int d);
        int         sz;
        logic [7:0] e;
        sz = (d == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            n_total++;
            $display("FAIL unexpected_byte%0d: got %0h expected no byte", d, tx_data[d]);
        end else begin
            e = (d == 0) ? q0[0] : q1[0];
            check($sformatf("tx_byte%0d", d), int'(tx_data[d]), int'(e));
            if (tx_ready) begin
                if (d == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (tx_valid[0] === 1'b1) mon(0);
        if (tx_valid[1] === 1'b1) mon(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        nframes = 0;
        for (int d = 0; d < 2; d++) begin
            remaining[d] = 0;
            ovr_m[d]     = 0;
        end

        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        check("reset_tx_data0", int'(tx_data[0]), 0);
        check("reset_tx_data1", int'(tx_data[1]), 0);

        // Post-reset frame with known fields.
        pos = {16'h0008, 16'h0060}; rem = '0; spd = '0; btn = '0; exit_flag = 1'b0;
        cycle(1'b1, 1'b1, 1'b1);
        drain();

        // Same frame under alternating backpressure.
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 80; i++) cycle(1'b0, 1'(i % 2), 1'b1);
        drain();

        // Overrun: strobes at cycles 0 and 5, then a frame carrying counter 2.
        cycle(1'b0, 1'b1, 1'b0);
        rand_fields();
        cycle(1'b1, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b1, 1'b1);
        rand_fields();
        cycle(1'b1, 1'b1, 1'b1);
        drain();
        rand_fields();
        cycle(1'b1, 1'b1, 1'b1);
        drain();

        // Back-to-back: new strobe coincident with the final handshake.
        rand_fields();
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40 && remaining[0] != 1; i++) begin
            rand_fields();
            cycle(1'b0, 1'b1, 1'b1);
        end
        rand_fields();
        cycle(1'b1, 1'b1, 1'b1);
        drain();

        // Decimation: six strobes 40 cycles apart from reset.
        cycle(1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 6; f++) begin
            rand_fields();
            cycle(1'b1, 1'b1, 1'b1);
            repeat (39) cycle(1'b0, 1'b1, 1'b1);
        end

        // Byte 3 boundary: exit set with all buttons.
        pos = $urandom; exit_flag = 1'b1; btn = 6'h3F;
        cycle(1'b1, 1'b1, 1'b1);
        drain();

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_fields();
            cycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0), 1'b1);
        end
        drain();

        // Reset while byte 10 is presented.
        rand_fields();
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40 && remaining[0] > 15; i++) cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        rand_fields();
        cycle(1'b1, 1'b1, 1'b1);
        drain();

        // Counter wrap: 65536 consecutive strobes, then one more frame.
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 65536; i++) begin
            rand_fields();
            cycle(1'b1, 1'b1, 1'b1);
        end
        drain();
        rand_fields();
        cycle(1'b1, 1'b1, 1'b1);
        drain();
        repeat (3) cycle(1'b0, 1'b1, 1'b1);

        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
